// File: rtl/pipeline_stage_controller_pkg.sv
// rtl/pipeline_stage_controller_pkg.sv - shared mode codes, FSM states and default stage indices
package pipeline_stage_controller_pkg;

  localparam logic MODE_MULTICYCLE = 1'b0;
  localparam logic MODE_PIPELINED  = 1'b1;

  typedef enum logic [1:0] {
    ST_RESET_HOLD = 2'd0,
    ST_RUN        = 2'd1,
    ST_DRAIN      = 2'd2,
    ST_HALTED     = 2'd3
  } state_t;

  localparam int STAGE_IF  = 0;
  localparam int STAGE_ID  = 1;
  localparam int STAGE_EX  = 2;
  localparam int STAGE_MEM = 3;
  localparam int STAGE_WB  = 4;

  localparam int DEFAULT_NUM_STAGES = STAGE_WB + 1;

endpackage

// File: rtl/pipeline_stage_controller_stage_valid_tracker.sv
// rtl/pipeline_stage_controller_stage_valid_tracker.sv - per-stage valid shift register with flush mask
module stage_valid_tracker
  import pipeline_stage_controller_pkg::*;
#(
  parameter int NUM_STAGES  = DEFAULT_NUM_STAGES,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic                  advance,
  input  logic                  insert,
  input  logic                  flush,
  output logic [NUM_STAGES-1:0] valid
);

  logic [NUM_STAGES-1:0] valid_next;

  // Shift every slot one stage older, insert at fetch, and kill the wrong-path slots on a flush
  always_comb begin
    valid_next = {valid[NUM_STAGES-2:0], insert};
    for (int i = 1; i < NUM_STAGES; i++) begin
      if (flush && (i <= FLUSH_DEPTH)) valid_next[i] = 1'b0;
    end
  end

  // Fetch slot becomes valid on entering RUN; afterwards the register moves only on an advance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) valid <= '0;
    else if (load) valid <= NUM_STAGES'(1) << STAGE_IF;
    else if (advance) valid <= valid_next;
  end

endmodule

// File: rtl/pipeline_stage_controller.sv
// rtl/pipeline_stage_controller.sv - N-stage sequencer producing stage, PC and commit write enables
module pipeline_stage_controller
  import pipeline_stage_controller_pkg::*;
#(
  parameter int NUM_STAGES        = DEFAULT_NUM_STAGES,
  parameter int RAM_WREN_STAGE    = STAGE_MEM,
  parameter int REG_WREN_STAGE    = STAGE_WB,
  parameter int FLUSH_DEPTH       = 2,
  parameter int RESET_HOLD_CYCLES = 2,
  parameter int COUNT_WIDTH       = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   mode,
  input  logic                   stall_req,
  input  logic                   flush_req,
  input  logic                   halt_req,
  output logic                   pc_wren,
  output logic [NUM_STAGES-2:0]  stage_wren,
  output logic                   ram_wren,
  output logic                   reg_wren,
  output logic                   stage_reset_n,
  output logic [NUM_STAGES-1:0]  stage_valid,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] retired_count
);

  localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

  state_t                state_q, state_d;
  logic [HOLD_W-1:0]     hold_q;
  logic                  mode_q;
  logic [NUM_STAGES-1:0] phase_q;
  logic [NUM_STAGES-1:0] pipe_valid;
  logic                  halt_pending_q, flush_pending_q;
  logic                  active, advance, pipe, halt_eff, flush_eff;
  logic                  retire, apply_flush, enter_run;

  assign active    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign advance   = active && !stall_req;
  assign pipe      = (mode_q == MODE_PIPELINED);
  assign halt_eff  = halt_pending_q || halt_req;
  assign flush_eff = pipe && (flush_pending_q || flush_req);
  assign enter_run = (state_q == ST_RESET_HOLD) && (state_d == ST_RUN);

  assign halted        = (state_q == ST_HALTED);
  assign stage_reset_n = (state_q != ST_RESET_HOLD);
  assign stage_valid   = pipe ? pipe_valid : phase_q;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_RESET_HOLD;
    else state_q <= state_d;
  end

  // Next state and write enables; every enable hangs off advance, so a stall gates them all
  always_comb begin
    state_d     = state_q;
    pc_wren     = 1'b0;
    stage_wren  = '0;
    ram_wren    = 1'b0;
    reg_wren    = 1'b0;
    retire      = 1'b0;
    apply_flush = 1'b0;
    unique case (state_q)
      ST_RESET_HOLD: if (hold_q == HOLD_LAST) state_d = ST_RUN;
      ST_RUN, ST_DRAIN: begin
        if (advance) begin
          if (pipe) begin
            stage_wren  = '1;
            pc_wren     = (state_q == ST_RUN) || flush_eff;
            ram_wren    = pipe_valid[RAM_WREN_STAGE];
            reg_wren    = pipe_valid[REG_WREN_STAGE];
            retire      = pipe_valid[NUM_STAGES-1];
            apply_flush = flush_eff;
            if ((state_q == ST_RUN) && halt_eff) state_d = ST_DRAIN;
            else if ((state_q == ST_DRAIN) && (pipe_valid == '0)) state_d = ST_HALTED;
          end else begin
            stage_wren = phase_q[NUM_STAGES-2:0];
            ram_wren   = phase_q[RAM_WREN_STAGE];
            reg_wren   = phase_q[REG_WREN_STAGE];
            pc_wren    = phase_q[NUM_STAGES-1];
            retire     = phase_q[NUM_STAGES-1];
            if (phase_q[NUM_STAGES-1] && halt_eff) state_d = ST_HALTED;
          end
        end
      end
      default: ;
    endcase
  end

  // Reset-hold counter and mode capture at the moment the core starts running
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
      mode_q <= MODE_MULTICYCLE;
    end else if (state_q == ST_RESET_HOLD) begin
      if (enter_run) mode_q <= mode;
      else hold_q <= hold_q + HOLD_W'(1);
    end
  end

  // A halt waits until it can act; a flush is remembered across stalls and consumed by the next advance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      halt_pending_q  <= 1'b0;
      flush_pending_q <= 1'b0;
    end else begin
      halt_pending_q  <= ((state_d == ST_RESET_HOLD) || (state_d == ST_RUN)) && halt_eff;
      flush_pending_q <= active && flush_eff && !advance;
    end
  end

  // Multicycle one-hot phase: starts at fetch, rotates per non-stalled cycle, clears on halt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) phase_q <= '0;
    else if (enter_run) phase_q <= NUM_STAGES'(1) << STAGE_IF;
    else if (advance && !pipe) begin
      if (state_d == ST_HALTED) phase_q <= '0;
      else phase_q <= {phase_q[NUM_STAGES-2:0], phase_q[NUM_STAGES-1]};
    end
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) retired_count <= '0;
    else if (retire) retired_count <= retired_count + COUNT_WIDTH'(1);
  end

  stage_valid_tracker #(
    .NUM_STAGES (NUM_STAGES),
    .FLUSH_DEPTH(FLUSH_DEPTH)
  ) u_valid (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (enter_run && (mode == MODE_PIPELINED)),
    .advance(advance && pipe),
    .insert (state_q == ST_RUN),
    .flush  (apply_flush),
    .valid  (pipe_valid)
  );

endmodule
